bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Iterative binary-to-BCD converter (shift-add-3, one bit per clock). Sits between the
//  16-bit up/down counter and the 4-digit 7-segment scanner: takes the binary count and
//  returns decimal digits, so the display shows 0-9999 instead of hex. Digits above the
//  display width raise an overflow flag that drives an LED.
// PARAMETERS
//  BIN_W   16  binary input width; conversion takes BIN_W shift cycles
//  DIGITS  5   BCD digits produced; must satisfy 10**DIGITS > 2**BIN_W-1
// PORTS
//  clk     in   1          system clock; all state on rising edge
//  rst_n   in   1          asynchronous, active-low reset
//  start   in   1          request conversion of bin; sampled only while busy=0
//  bin     in   BIN_W      binary value, captured on the accepting edge
//  busy    out  1          conversion in progress; start ignored while high
//  done    out  1          one-cycle pulse: bcd/disp/ovf updated this cycle
//  bcd     out  4*DIGITS   full BCD result, digit 0 in [3:0]; held until next done
//  disp    out  16         lowest 4 digits of bcd, wired to the display hexs input
//  ovf     out  1          1 when any digit above digit 3 is non-zero
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, busy=0, done=0, bcd=0, disp=0,
//    ovf=0, shift/scratch registers=0. Reset mid-conversion aborts; no done pulse follows.
//  - FSM: IDLE --start--> SHIFT --(BIN_W-th shift)--> IDLE. No separate DONE state.
//  - Accept edge (IDLE, start=1): bin -> shift reg, scratch BCD <- 0, iter cnt <- 0, busy<-1.
//  - Each SHIFT edge: every scratch digit >=5 gets +3 (4-bit, no carry out of digit),
//    then {scratch, shift reg} shifts left 1; MSB of shift reg enters scratch bit 0.
//  - On the BIN_W-th SHIFT edge the post-shift scratch value is written straight to bcd;
//    disp, ovf updated from that same value; done<-1, busy<-0, state IDLE.
//  - Latency: done high exactly BIN_W clocks after the accepting edge (16 for defaults).
//  - done is a single-cycle pulse; start high during the done cycle is accepted
//    (busy already 0), giving back-to-back conversions with period BIN_W+1 clocks.
//  - start while busy=1 is ignored, not queued; bin changes while busy have no effect.
//  - start held high continuously: conversions repeat every BIN_W+1 clocks, each
//    capturing bin on its accept edge.
//  - Iteration counter width clog2(BIN_W+1); no wrap within a conversion.
//  - Max input 2**BIN_W-1 (65535) -> bcd=0x65535, ovf=1, disp=0x5535.
//  - Outputs bcd/disp/ovf change only on done edges; stable otherwise.
// STRUCTURE
//  - Shared header bin2bcd_defs.vh: state encodings (ST_IDLE, ST_SHIFT), BCD digit
//    width constant (4), DISP_DIGITS=4.
//  - One sub-module: bcd_add3 (combinational, 4-bit in/out: d>=5 ? d+3 : d),
//    instantiated DIGITS times in a generate loop.
//  - Top: FSM, iteration counter, shift reg, scratch reg, output regs.
// TESTING
//  1 rst_n low, then release, no start -> busy=0 done=0 bcd=0 disp=0 ovf=0 indefinitely.
//  2 bin=16'd1234, start 1 cycle -> done after exactly 16 clks; bcd=20'h01234,
//    disp=16'h1234, ovf=0; bin=0 -> bcd=0, ovf=0.
//  3 bin=9999 -> disp=16'h9999 ovf=0; bin=10000 -> bcd=20'h10000 disp=0 ovf=1;
//    bin=65535 -> bcd=20'h65535 disp=16'h5535 ovf=1.
//  4 start=1 at accept, bin=42; pulse start again and change bin=7 at clk 5 -> ignored;
//    done at 16 with disp=16'h0042, single done pulse only.
//  5 rst_n low at clk 8 of conversion of 500 -> outputs 0 immediately (async), no done;
//    new start after release with 500 -> disp=16'h0500.
//  6 start held high, bin stepping 0..20 each conversion -> done every 17 clks, each
//    disp equals decimal of bin captured at its accept edge; scoreboard vs reference model.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int unsigned BCD_W       = 4;
  localparam int unsigned DISP_DIGITS = 4;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = (d >= 4'd5) ? d + 4'd3 : d;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic [15:0]               disp,
  output logic                      ovf
);

  localparam int unsigned SCR_W  = BCD_W * DIGITS;
  localparam int unsigned DISP_W = BCD_W * DISP_DIGITS;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

  state_t             state_q;
  state_t             state_d;
  logic               accept;
  logic               last;
  logic [BIN_W-1:0]   shift_q;
  logic [SCR_W-1:0]   scratch_q;
  logic [SCR_W-1:0]   adj;
  logic [SCR_W-1:0]   scratch_nx;
  logic [CNT_W-1:0]   cnt_q;
  logic [SCR_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               ovf_nx;
  logic               done_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d (scratch_q[i*BCD_W +: BCD_W]),
      .q (adj[i*BCD_W +: BCD_W])
    );
  end

  assign scratch_nx = {adj[SCR_W-2:0], shift_q[BIN_W-1]};

  // The bit shifted out of the top digit is also folded into ovf; it can only be
  // set when DIGITS is too small for BIN_W.
  if (DIGITS > DISP_DIGITS) begin : g_ovf
    assign ovf_nx = adj[SCR_W-1] | (|scratch_nx[SCR_W-1:DISP_W]);
  end else begin : g_no_ovf
    assign ovf_nx = adj[SCR_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last)  state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == ST_SHIFT);
    accept = (state_q == ST_IDLE) && start;
    last   = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(BIN_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        shift_q   <= bin;
        scratch_q <= '0;
        cnt_q     <= '0;
      end else if (busy) begin
        shift_q   <= {shift_q[BIN_W-2:0], 1'b0};
        scratch_q <= scratch_nx;
        cnt_q     <= cnt_q + CNT_W'(1);
        if (last) begin
          bcd_q <= scratch_nx;
          ovf_q <= ovf_nx;
        end
      end
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;
  assign disp = bcd_q[DISP_W-1:0];
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expectations, a monitor checks each done.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [15:0] disp;
  logic        ovf;

  typedef struct {
    logic [19:0] bcd;
    logic [15:0] disp;
    logic        ovf;
    int unsigned due;
  } exp_t;

  exp_t        sbq[$];
  int unsigned total;
  int unsigned bad;
  int unsigned cyc;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .disp  (disp),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [19:0] dec2bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          chk("bcd",     32'(bcd),  32'(e.bcd));
          chk("disp",    32'(disp), 32'(e.disp));
          chk("ovf",     32'(ovf),  32'(e.ovf));
          chk("latency", cyc,       e.due);
        end
      end
    end
  end

  task automatic issue(input logic [15:0] v, input logic [19:0] eb,
                       input logic [15:0] ed, input logic eo);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    sbq.push_back('{eb, ed, eo, cyc + 17});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=pending required=none (t=%0t)", $time);
      sbq.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_bcd"},  32'(bcd),  32'd0);
    chk({tag, "_disp"}, 32'(disp), 32'd0);
    chk({tag, "_ovf"},  32'(ovf),  32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;

    // 1: reset state, idle with no start
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk_zero("idle");
    end

    // 2-3: directed conversions
    issue(16'd1234,  20'h01234, 16'h1234, 1'b0); wait_drain();
    issue(16'd0,     20'h00000, 16'h0000, 1'b0); wait_drain();
    issue(16'd9999,  20'h09999, 16'h9999, 1'b0); wait_drain();
    issue(16'd10000, 20'h10000, 16'h0000, 1'b1); wait_drain();
    issue(16'd65535, 20'h65535, 16'h5535, 1'b1); wait_drain();

    // 4: start and bin changes while busy are ignored; outputs held mid-conversion
    @(negedge clk);
    bin   = 16'd42;
    start = 1'b1;
    sbq.push_back('{20'h00042, 16'h0042, 1'b0, cyc + 17});
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    bin   = 16'd7;
    start = 1'b1;
    chk("held_bcd",  32'(bcd),  32'h65535);
    chk("held_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);

    // 5: asynchronous reset mid-conversion aborts without a done pulse
    @(negedge clk);
    bin   = 16'd500;
    start = 1'b1;
    sbq.push_back('{20'h00500, 16'h0500, 1'b0, cyc + 17});
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("abort");
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(16'd500, 20'h00500, 16'h0500, 1'b0); wait_drain();

    // 6: start held high, back-to-back conversions every 17 clocks
    for (int unsigned v = 0; v <= 20; v++) begin
      @(negedge clk);
      bin   = 16'(v);
      start = 1'b1;
      sbq.push_back('{dec2bcd(v), dec2bcd(v)[15:0], 1'b0, cyc + 17});
      repeat (16) @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
